// File: rtl/dps_pkg.sv
// Shared types and helpers for the double-pulse sequencer.
// Phase lengths are counted in clk cycles on a 16-bit counter.
package dps_pkg;

  typedef enum logic [2:0] {
    IDLE,
    P1,
    GAP,
    P2,
    COOL
  } state_e;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned CNT_MAX = (2 ** CNT_W) - 1;

  function automatic int unsigned us2cyc(
    input int unsigned us,
    input int unsigned cyc_per_us
  );
    return us * cyc_per_us;
  endfunction

endpackage

// File: rtl/dps_debounce.sv
// Trigger conditioning: 2-flop synchroniser plus optional debounce.
// Debounce compiled in only with `define DPS_DEBOUNCE_EN.
module dps_debounce
  import dps_pkg::*;
#(
  parameter int unsigned DEB_CYC = 300
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tem_i,
  output logic sync_o,
  output logic filt_o
);

  logic [1:0] sync_q;

  if (DEB_CYC == 0 || DEB_CYC > CNT_MAX) begin : g_bad_deb
    $error("dps_debounce: DEB_CYC out of range");
  end

  // Two-flop synchroniser for the asynchronous trigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], tem_i};
  end

  assign sync_o = sync_q[1];

`ifdef DPS_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DEB_E = CNT_W'(DEB_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;

  // Count consecutive cycles the input differs from the filtered level.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == DEB_E) filt_d = sync_q[1];
      else                cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  // Filtered level and stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;
`else
  assign filt_o = sync_q[1];
`endif

endmodule

// File: rtl/double_pulse_seq.sv
// Double-pulse burst sequencer for the K1/K2 gate drivers.
// Optional trigger debounce via `define DPS_DEBOUNCE_EN.
module double_pulse_seq
  import dps_pkg::*;
#(
  parameter int unsigned CLK_PER_US = 100,
  parameter int unsigned DEB_US     = 2,
  parameter int unsigned T1_US      = 30,
  parameter int unsigned TGAP_US    = 20,
  parameter int unsigned T2_US      = 30,
  parameter int unsigned COOL_US    = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic TEM,
  input  logic abort,
  output logic K1,
  output logic K2,
  output logic busy,
  output logic done,
  output logic fault
);

  localparam int unsigned T1_C = us2cyc(T1_US, CLK_PER_US);
  localparam int unsigned TG_C = us2cyc(TGAP_US, CLK_PER_US);
  localparam int unsigned T2_C = us2cyc(T2_US, CLK_PER_US);
  localparam int unsigned CL_C = us2cyc(COOL_US, CLK_PER_US);
  localparam int unsigned DB_C = us2cyc(DEB_US + 1, CLK_PER_US);

  if (T1_C > CNT_MAX || TG_C > CNT_MAX ||
      T2_C > CNT_MAX || CL_C > CNT_MAX ||
      T1_C == 0 || TG_C == 0 ||
      T2_C == 0 || CL_C == 0) begin : g_bad_len
    $error("double_pulse_seq: phase length out of range");
  end

  localparam logic [CNT_W-1:0] T1_E = CNT_W'(T1_C - 1);
  localparam logic [CNT_W-1:0] TG_E = CNT_W'(TG_C - 1);
  localparam logic [CNT_W-1:0] T2_E = CNT_W'(T2_C - 1);
  localparam logic [CNT_W-1:0] CL_E = CNT_W'(CL_C - 1);

  logic       sync, filt;
  logic [1:0] vld_q;
  logic       arm_q, filt_q, rise_q;

  dps_debounce #(
    .DEB_CYC(DB_C)
  ) u_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .tem_i (TEM),
    .sync_o(sync),
    .filt_o(filt)
  );

  // Registered rising edge; a trigger already high when reset
  // releases is not a fresh edge, so arm only after seeing it low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      arm_q  <= 1'b0;
      filt_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      vld_q  <= {vld_q[0], 1'b1};
      arm_q  <= arm_q | (vld_q[1] & ~sync);
      filt_q <= filt;
      rise_q <= arm_q & filt & ~filt_q;
    end
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_d, done_d;
  logic             active;

  assign active = (state_q == P1) || (state_q == GAP) ||
                  (state_q == P2);

  // Next state, phase counter and flag updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    fault_d = fault;
    done_d  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      fault_d = 1'b0;
    end else if (abort && active) begin
      state_d = IDLE;
      cnt_d   = '0;
      fault_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (rise_q) state_d = P1;
        end
        P1: if (cnt_q == T1_E) begin
          state_d = GAP;
          cnt_d   = '0;
        end
        GAP: if (cnt_q == TG_E) begin
          state_d = P2;
          cnt_d   = '0;
        end
        P2: if (cnt_q == T2_E) begin
          state_d = COOL;
          cnt_d   = '0;
        end
        COOL: if (cnt_q == CL_E) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      K1      <= 1'b0;
      K2      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      K1      <= (state_d == P1) || (state_d == P2);
      K2      <= (state_d == P1) || (state_d == P2);
      busy    <= (state_d != IDLE);
      done    <= done_d;
      fault   <= fault_d;
    end
  end

endmodule

// File: tb/tb_double_pulse_seq.sv
// Self-checking bench for double_pulse_seq (default parameters).
// Follows DPS_DEBOUNCE_EN to pick the expected trigger latency.
module tb_double_pulse_seq;

  localparam int CPU  = 100;
  localparam int T1   = 30 * CPU;
  localparam int TG   = 20 * CPU;
  localparam int T2   = 30 * CPU;
  localparam int CL   = 100 * CPU;
`ifdef DPS_DEBOUNCE_EN
  localparam int N    = (2 + 1) * CPU;
`else
  localparam int N    = 0;
`endif
  localparam int LAT  = 4 + N;
  localparam int ACT  = T1 + TG + T2;
  localparam int TOT  = ACT + CL;

  logic clk = 1'b0;
  logic rst_n, enable, TEM, abort;
  logic K1, K2, busy, done, fault;

  int checks = 0;
  int errors = 0;

  double_pulse_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable),
    .TEM   (TEM),
    .abort (abort),
    .K1    (K1),
    .K2    (K2),
    .busy  (busy),
    .done  (done),
    .fault (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic quiet();
    TEM = 1'b0;
    repeat (N + 10) tick();
  endtask

  // Samples until K1 is seen high, bounded.
  task automatic wait_k1(output int s);
    s = 0;
    while (K1 !== 1'b1 && s < LAT + 100) begin
      tick();
      s++;
    end
  endtask

  // Length of a run of K1 == v starting at the current sample.
  task automatic run_len(input logic v, input int lim,
                         output int n, output int bad);
    n = 0;
    bad = 0;
    while (K1 === v && n < lim) begin
      if (K2 !== K1 || busy !== 1'b1) bad++;
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; TEM = 1'b0; abort = 1'b0;
    repeat (3) tick();
    checks++;
    if (K1 !== 1'b0) begin
      errors++; $display("FAIL rst_k1 got %b want 0", K1);
    end
    checks++;
    if (K2 !== 1'b0) begin
      errors++; $display("FAIL rst_k2 got %b want 0", K2);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy got %b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL rst_done got %b want 0", done);
    end
    checks++;
    if (fault !== 1'b0) begin
      errors++; $display("FAIL rst_fault got %b want 0", fault);
    end
    rst_n = 1'b1;
    repeat (10) tick();
  endtask

  task automatic test_full_burst();
    int s, n, bad, dn;
    quiet();
    TEM = 1'b1;
    wait_k1(s);
    checks++;
    if (s != LAT) begin
      errors++; $display("FAIL lat got %0d want %0d", s, LAT);
    end
    run_len(1'b1, T1 + 10, n, bad);
    checks++;
    if (n != T1) begin
      errors++; $display("FAIL p1_len got %0d want %0d", n, T1);
    end
    run_len(1'b0, TG + 10, n, s);
    bad += s;
    checks++;
    if (n != TG) begin
      errors++; $display("FAIL gap_len got %0d want %0d", n, TG);
    end
    run_len(1'b1, T2 + 10, n, s);
    bad += s;
    checks++;
    if (n != T2) begin
      errors++; $display("FAIL p2_len got %0d want %0d", n, T2);
    end
    n = 0;
    while (done !== 1'b1 && n < CL + 10) begin
      if (K1 !== 1'b0 || K2 !== 1'b0 || busy !== 1'b1) bad++;
      tick();
      n++;
    end
    checks++;
    if (n != CL) begin
      errors++; $display("FAIL cool_len got %0d want %0d", n, CL);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL burst_busy_k2 got %0d bad want 0", bad);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL busy_at_done got %b want 0", busy);
    end
    dn = 0;
    repeat (50) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++; $display("FAIL done_once got %0d extra want 0", dn);
    end
  endtask

`ifdef DPS_DEBOUNCE_EN
  task automatic test_glitch();
    int seen;
    quiet();
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      if (i % 150 == 0) TEM = ~TEM;
      tick();
      if (busy === 1'b1 || K1 === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL glitch got %0d busy want 0", seen);
    end
  endtask
`endif

  task automatic test_abort();
    int s, dn;
    quiet();
    TEM = 1'b1;
    wait_k1(s);
    repeat (T1 + TG + 1000) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (K1 !== 1'b0 || K2 !== 1'b0) begin
      errors++;
      $display("FAIL abort_k got %b%b want 00", K1, K2);
    end
    checks++;
    if (fault !== 1'b1) begin
      errors++; $display("FAIL abort_fault got %b want 1", fault);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL abort_busy got %b want 0", busy);
    end
    dn = 0;
    repeat (50) begin
      tick();
      if (done === 1'b1) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++; $display("FAIL abort_done got %0d want 0", dn);
    end
    enable = 1'b0;
    tick();
    enable = 1'b1;
    checks++;
    if (fault !== 1'b0) begin
      errors++; $display("FAIL fault_clr got %b want 0", fault);
    end
  endtask

  task automatic test_back_to_back();
    int s, r, seen;
    quiet();
    TEM = 1'b1;
    wait_k1(s);
    repeat (T1 + 100) tick();
    TEM = 1'b0;
    repeat (N + 20) tick();
    TEM = 1'b1;
    r = T1 + 100 + N + 20;
    while (done !== 1'b1 && r < TOT + 20) begin
      tick();
      r++;
    end
    checks++;
    if (r != TOT) begin
      errors++; $display("FAIL b2b_done got %0d want %0d", r, TOT);
    end
    seen = 0;
    repeat (LAT + 100) begin
      tick();
      if (busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL b2b_queued got %0d want 0", seen);
    end
    TEM = 1'b0;
    repeat (N + 10) tick();
    TEM = 1'b1;
    wait_k1(s);
    checks++;
    if (s != LAT) begin
      errors++; $display("FAIL b2b_lat got %0d want %0d", s, LAT);
    end
    enable = 1'b0;
    tick();
    enable = 1'b1;
    checks++;
    if (K1 !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL en_drop got %b%b want 00", K1, busy);
    end
  endtask

  task automatic test_reset_mid();
    int s, seen;
    quiet();
    TEM = 1'b1;
    wait_k1(s);
    repeat (100) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (K1 !== 1'b0 || K2 !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got %b%b%b want 000", K1, K2, busy);
    end
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (LAT + 500) begin
      tick();
      if (busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL rst_rearm got %0d want 0", seen);
    end
  endtask

  // Timeline model: K1/busy/done/fault as functions of the
  // sample offset r from the first expected K1-high sample.
  task automatic test_random();
    int a, mode, r, ek, eb, ed, ef;
    int bk, bb, bd, bf, fr;
    for (int it = 0; it < 3; it++) begin
      quiet();
      repeat ($urandom_range(5, 40)) tick();
      mode = $urandom_range(0, 1);
      a = $urandom_range(0, ACT - 1);
      bk = 0; bb = 0; bd = 0; bf = 0; fr = 0;
      TEM = 1'b1;
      for (int s = 1; s <= LAT + a + 6; s++) begin
        tick();
        r = s - LAT;
        ek = (r >= 0) && ((r < T1) ||
             (r >= T1 + TG && r < ACT));
        eb = (r >= 0) && (r < TOT);
        ed = (r == TOT);
        ef = 0;
        if (r > a) begin
          ek = 0; eb = 0; ed = 0;
          ef = (mode == 0);
        end
        if (K1 !== ek[0] || K2 !== ek[0]) begin
          if (bk == 0) fr = r;
          bk++;
        end
        if (busy !== eb[0]) bb++;
        if (done !== ed[0]) bd++;
        if (fault !== ef[0]) bf++;
        if (r == a) begin
          if (mode == 0) abort = 1'b1;
          else           enable = 1'b0;
        end
        if (r == a + 1) begin
          abort = 1'b0;
          enable = 1'b1;
        end
      end
      checks++;
      if (bk != 0) begin
        errors++;
        $display("FAIL rnd_k it%0d m%0d a%0d got %0d bad at r=%0d want 0",
                 it, mode, a, bk, fr);
      end
      checks++;
      if (bb != 0) begin
        errors++;
        $display("FAIL rnd_busy it%0d got %0d bad want 0", it, bb);
      end
      checks++;
      if (bd != 0) begin
        errors++;
        $display("FAIL rnd_done it%0d got %0d bad want 0", it, bd);
      end
      checks++;
      if (bf != 0) begin
        errors++;
        $display("FAIL rnd_fault it%0d got %0d bad want 0", it, bf);
      end
      enable = 1'b0;
      tick();
      enable = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_full_burst();
`ifdef DPS_DEBOUNCE_EN
    test_glitch();
`endif
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
